// File: rtl/dm_m.sv
// M-stage data memory: word/half/byte stores with lane merge, extended loads, alignment/range errors.
// Optional store trace enabled by defining DM_TRACE_EN.
module dm_m #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_M,
    input  logic [31:0] ALUOut_M,
    input  logic [31:0] WriteData_M,
    input  logic        MemWrite_M,
    input  logic        MemRead_M,
    input  logic [2:0]  MemOp_M,
    output logic [31:0] ReadData_M,
    output logic [3:0]  ByteEn_M,
    output logic        AddrErr_M
);

    typedef enum logic [2:0] {
        OP_W  = 3'b000,
        OP_HU = 3'b001,
        OP_H  = 3'b010,
        OP_BU = 3'b011,
        OP_B  = 3'b100
    } mem_op_e;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              access;
    logic              legal;
    logic              misaligned;
    logic              out_of_range;
    logic [3:0]        lane_mask;
    logic [31:0]       cur_word;
    logic [31:0]       shifted;
    logic [31:0]       wr_data;
    logic [31:0]       merged;

    assign idx          = ALUOut_M[ADDR_W+1:2];
    assign lane         = ALUOut_M[1:0];
    assign access       = MemRead_M | MemWrite_M;
    assign out_of_range = ALUOut_M >= 32'(4 * DEPTH_WORDS);
    assign cur_word     = mem[idx];
    assign shifted      = cur_word >> {lane, 3'b000};
    // Aligned accesses only: shifting the right-aligned store data by the lane places it on the enabled lanes.
    assign wr_data      = WriteData_M << {lane, 3'b000};

    always_comb begin
        lane_mask  = '0;
        misaligned = 1'b0;
        legal      = 1'b1;
        case (mem_op_e'(MemOp_M))
            OP_W: begin
                lane_mask  = 4'b1111;
                misaligned = |lane;
            end
            OP_HU, OP_H: begin
                lane_mask  = lane[1] ? 4'b1100 : 4'b0011;
                misaligned = lane[0];
            end
            OP_BU, OP_B: lane_mask = 4'b0001 << lane;
            default: legal = 1'b0;
        endcase
    end

    assign AddrErr_M = access & (misaligned | out_of_range);
    assign ByteEn_M  = (access && legal && !AddrErr_M) ? lane_mask : 4'b0000;

    always_comb begin
        ReadData_M = '0;
        if (MemRead_M && legal && !AddrErr_M) begin
            case (mem_op_e'(MemOp_M))
                OP_W:    ReadData_M = shifted;
                OP_HU:   ReadData_M = {16'h0000, shifted[15:0]};
                OP_H:    ReadData_M = {{16{shifted[15]}}, shifted[15:0]};
                OP_BU:   ReadData_M = {24'h000000, shifted[7:0]};
                OP_B:    ReadData_M = {{24{shifted[7]}}, shifted[7:0]};
                default: ReadData_M = '0;
            endcase
        end
    end

    always_comb begin
        merged = cur_word;
        for (int unsigned k = 0; k < 4; k++) begin
            if (ByteEn_M[k]) merged[8*k +: 8] = wr_data[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (MemWrite_M && (ByteEn_M != 4'b0000)) begin
            mem[idx] <= merged;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && MemWrite_M && (ByteEn_M != 4'b0000))
            $display("%0t@%08h: *%08h <= %08h", $time, PC_M, {ALUOut_M[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^PC_M;
`endif

endmodule
